// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute controller: state encodings,
// opcode defaults and the watchdog defaults reused by the execute unit.
package fetch_sequencer_pkg;

  localparam int         DEF_OPCODE_W    = 5;
  localparam logic [4:0] DEF_HALT_OPCODE = 5'h1F;
  localparam logic [4:0] DEF_JMP_OPCODE  = 5'h1E;
  localparam int         DEF_TIMEOUT     = 15;
  localparam int         DEF_TMO_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALTED = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Where the sequencer goes once an instruction has completed.
  function automatic state_t after_instr(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/fetch_sequencer_exec_watchdog.sv
// Execute-phase watchdog: counts EXEC cycles without exec_done and flags the
// cycle on which the count would reach TIMEOUT.
module fetch_sequencer_exec_watchdog #(
  parameter int TMO_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TMO_W'(1);
    end
  end

  // High on the edge where the count steps to TIMEOUT.
  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit core: sequences
// memory read, IR load, PC step, opcode classification and execute handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                  OPCODE_W    = DEF_OPCODE_W,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE,
  parameter logic [OPCODE_W-1:0] JMP_OPCODE  = DEF_JMP_OPCODE,
  parameter int                  TIMEOUT     = DEF_TIMEOUT,
  parameter int                  TMO_W       = DEF_TMO_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                mem_rd_ack,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                exec_done,
  output logic                mem_rd_req,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                exec_start,
  output logic                halted,
  output logic                fault,
  output logic [2:0]          state_dbg
);

  // Handshakes: mem_rd_req is a level held from the first FETCH cycle until the
  // edge that samples mem_rd_ack high; an ack outside FETCH is ignored.
  // exec_start is a one-cycle pulse; exec_done is sampled only while in EXEC.

  state_t state_q, state_d;
  logic   is_halt, is_jmp;
  logic   wd_clear, wd_enable, wd_expired;

  assign is_halt = (ir_opcode == HALT_OPCODE);
  assign is_jmp  = (ir_opcode == JMP_OPCODE);

  assign wd_clear  = (state_q == ST_DECODE);
  assign wd_enable = (state_q == ST_EXEC) && !exec_done;

  fetch_sequencer_exec_watchdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  if (mem_rd_ack) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_halt)     state_d = ST_HALTED;
        else if (is_jmp) state_d = after_instr(run);
        else             state_d = ST_EXEC;
      end
      // Completion takes priority over a watchdog expiring on the same edge.
      ST_EXEC: begin
        if (exec_done)       state_d = after_instr(run);
        else if (wd_expired) state_d = ST_FAULT;
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_rd_req <= 1'b0;
      ir_load    <= 1'b0;
      pc_inc     <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_rd_req <= (state_d == ST_FETCH);
      ir_load    <= (state_d == ST_LOAD);
      pc_inc     <= (state_d == ST_LOAD);
      halted     <= (state_d == ST_HALTED);
      fault      <= (state_d == ST_FAULT);
    end
  end

  // The opcode is only valid once the IR has latched, i.e. during DECODE itself,
  // so these two strobes decode the registered state against the registered IR.
  assign pc_load    = (state_q == ST_DECODE) && is_jmp;
  assign exec_start = (state_q == ST_DECODE) && !is_jmp && !is_halt;

  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an instruction-level reference process plus directed
// scenarios with hand-computed cycle expectations.
module tb_fetch_sequencer;

  localparam int S_IDLE   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_LOAD   = 2;
  localparam int S_DECODE = 3;
  localparam int S_EXEC   = 4;
  localparam int S_HALTED = 5;
  localparam int S_FAULT  = 6;
  localparam logic [4:0] OP_HALT = 5'h1F;
  localparam logic [4:0] OP_JMP  = 5'h1E;
  localparam int TMO = 15;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic mem_rd_ack = 1'b0;
  logic exec_done = 1'b0;
  logic [4:0] ir_opcode = '0;
  logic [4:0] mem_opcode = '0;
  logic mem_rd_req, ir_load, pc_inc, pc_load, exec_start, halted, fault;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int req_cnt, ld_cnt, ld_cyc, start_cnt;
  logic [2:0] exp_q[$];

  int   exp_state;
  logic exp_req, exp_ir, exp_pcinc, exp_pcload, exp_start, exp_halt, exp_fault;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_rd_ack (mem_rd_ack),
    .ir_opcode  (ir_opcode),
    .exec_done  (exec_done),
    .mem_rd_req (mem_rd_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .exec_start (exec_start),
    .halted     (halted),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  // Stand-in instruction register: latches the memory word's opcode on ir_load.
  always @(posedge clk) begin
    if (ir_load) ir_opcode <= mem_opcode;
  end

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic set_exp(input int st, input logic pl, input logic es);
    exp_state  = st;
    exp_req    = (st == S_FETCH);
    exp_ir     = (st == S_LOAD);
    exp_pcinc  = (st == S_LOAD);
    exp_pcload = pl;
    exp_start  = es;
    exp_halt   = (st == S_HALTED);
    exp_fault  = (st == S_FAULT);
  endtask

  task automatic next_edge(output bit ok);
    @(posedge clk or negedge rst_n);
    ok = (rst_n === 1'b1);
  endtask

  // Walks one instruction at a time; returns as soon as reset is asserted.
  task automatic model_thread();
    bit ok;
    bit from_idle;
    logic [4:0] opc;
    int n;
    from_idle = 1'b1;
    forever begin
      if (from_idle) begin
        set_exp(S_IDLE, 1'b0, 1'b0);
        do begin
          next_edge(ok);
          if (!ok) return;
        end while (run !== 1'b1);
      end
      set_exp(S_FETCH, 1'b0, 1'b0);
      do begin
        next_edge(ok);
        if (!ok) return;
      end while (mem_rd_ack !== 1'b1);
      opc = mem_opcode;
      set_exp(S_LOAD, 1'b0, 1'b0);
      next_edge(ok);
      if (!ok) return;
      set_exp(S_DECODE, opc == OP_JMP, (opc != OP_JMP) && (opc != OP_HALT));
      next_edge(ok);
      if (!ok) return;
      if (opc == OP_HALT) begin
        set_exp(S_HALTED, 1'b0, 1'b0);
        forever begin
          next_edge(ok);
          if (!ok) return;
        end
      end
      if (opc != OP_JMP) begin
        set_exp(S_EXEC, 1'b0, 1'b0);
        n = 0;
        forever begin
          next_edge(ok);
          if (!ok) return;
          if (exec_done === 1'b1) break;
          n++;
          if (n == TMO) begin
            set_exp(S_FAULT, 1'b0, 1'b0);
            forever begin
              next_edge(ok);
              if (!ok) return;
            end
          end
        end
      end
      from_idle = (run !== 1'b1);
    end
  endtask

  initial begin
    forever begin
      set_exp(S_IDLE, 1'b0, 1'b0);
      wait (rst_n === 1'b1);
      model_thread();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk3("state_dbg", state_dbg, 3'(exp_state));
    chk1("mem_rd_req", mem_rd_req, exp_req);
    chk1("ir_load", ir_load, exp_ir);
    chk1("pc_inc", pc_inc, exp_pcinc);
    chk1("pc_load", pc_load, exp_pcload);
    chk1("exec_start", exec_start, exp_start);
    chk1("halted", halted, exp_halt);
    chk1("fault", fault, exp_fault);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // 1: back-to-back ALU ops with immediate ack and done
    run = 1'b1; mem_rd_ack = 1'b1; exec_done = 1'b1; mem_opcode = 5'h01;
    apply_reset();
    chk3("t1_reset_state", state_dbg, 3'd0);
    chk1("t1_reset_req", mem_rd_req, 1'b0);
    exp_q = {3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk3($sformatf("t1_state_c%0d", c), state_dbg, exp_q.pop_front());
      if (c == 2) begin
        chk1("t1_ir_load_c2", ir_load, 1'b1);
        chk1("t1_pc_inc_c2", pc_inc, 1'b1);
      end
      if (c == 3) chk1("t1_exec_start_c3", exec_start, 1'b1);
    end

    // 2: ack delayed by three cycles
    run = 1'b1; mem_rd_ack = 1'b0; exec_done = 1'b1; mem_opcode = 5'h03;
    apply_reset();
    req_cnt = 0; ld_cnt = 0; ld_cyc = -1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (mem_rd_req) req_cnt++;
      if (ir_load) begin
        ld_cnt++;
        ld_cyc = c;
      end
      if (c == 4) mem_rd_ack = 1'b1;
      if (c == 5) mem_rd_ack = 1'b0;
    end
    chk_int("t2_req_cycles", req_cnt, 4);
    chk_int("t2_ir_load_pulses", ld_cnt, 1);
    chk_int("t2_ir_load_cycle", ld_cyc, 5);

    // 3: jump handled in DECODE, no execute phase
    run = 1'b1; mem_rd_ack = 1'b1; exec_done = 1'b0; mem_opcode = OP_JMP;
    apply_reset();
    start_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (exec_start) start_cnt++;
      if (c == 3) begin
        chk1("t3_pc_load_c3", pc_load, 1'b1);
        chk3("t3_state_c3", state_dbg, 3'd3);
      end
      if (c == 4) begin
        chk3("t3_state_c4", state_dbg, 3'd1);
        chk1("t3_req_c4", mem_rd_req, 1'b1);
      end
    end
    chk_int("t3_exec_start_count", start_cnt, 0);

    // 4: halt is sticky until reset
    run = 1'b1; mem_rd_ack = 1'b1; exec_done = 1'b0; mem_opcode = OP_HALT;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 3) chk1("t4_halted_decode", halted, 1'b0);
      if (c == 4) begin
        chk1("t4_halted_c4", halted, 1'b1);
        chk3("t4_state_c4", state_dbg, 3'd5);
      end
    end
    for (int k = 0; k < 6; k++) begin
      run = (k % 2 == 0);
      mem_rd_ack = (k % 3 == 0);
      exec_done = (k % 2 == 1);
      tick();
      chk1($sformatf("t4_halted_hold_%0d", k), halted, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk1("t4_halted_in_reset", halted, 1'b0);
    chk3("t4_state_in_reset", state_dbg, 3'd0);
    run = 1'b0; mem_rd_ack = 1'b0; exec_done = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk3("t4_idle_after_reset", state_dbg, 3'd0);
    chk1("t4_req_after_reset", mem_rd_req, 1'b0);

    // 5a: watchdog expires after 15 EXEC cycles
    run = 1'b1; mem_rd_ack = 1'b1; exec_done = 1'b0; mem_opcode = 5'h02;
    apply_reset();
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c == 18) begin
        chk3("t5a_state_c18", state_dbg, 3'd4);
        chk1("t5a_fault_c18", fault, 1'b0);
      end
      if (c == 19) begin
        chk1("t5a_fault_c19", fault, 1'b1);
        chk3("t5a_state_c19", state_dbg, 3'd6);
      end
      if (c == 21) chk1("t5a_fault_sticky", fault, 1'b1);
    end

    // 5b: done on the 15th EXEC cycle wins over the watchdog
    apply_reset();
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 18) exec_done = 1'b1;
      if (c == 19) begin
        exec_done = 1'b0;
        chk1("t5b_fault_c19", fault, 1'b0);
        chk3("t5b_state_c19", state_dbg, 3'd1);
      end
      if (c == 22) chk3("t5b_state_c22", state_dbg, 3'd4);
    end

    // 6a: asynchronous reset in FETCH and in EXEC
    run = 1'b1; mem_rd_ack = 1'b1; exec_done = 1'b0; mem_opcode = 5'h02;
    apply_reset();
    tick();
    chk1("t6_req_before_reset", mem_rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_req_async_reset", mem_rd_req, 1'b0);
    chk3("t6_state_async_reset_fetch", state_dbg, 3'd0);
    tick();
    apply_reset();
    for (int c = 1; c <= 4; c++) tick();
    chk3("t6_state_exec", state_dbg, 3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk3("t6_state_async_reset_exec", state_dbg, 3'd0);
    chk1("t6_fault_async_reset", fault, 1'b0);
    tick();

    // 6b: run dropped during EXEC parks in IDLE after done
    apply_reset();
    req_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 4) run = 1'b0;
      if (c == 5) exec_done = 1'b1;
      if (c == 6) begin
        exec_done = 1'b0;
        chk3("t6b_state_idle", state_dbg, 3'd0);
      end
      if (c >= 6 && mem_rd_req) req_cnt++;
    end
    chk_int("t6b_req_while_parked", req_cnt, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
